// File: rtl/grant_session_ctrl.sv
// Turns one-hot arbiter grants into timed resource sessions with a release pulse,
// per-user saturating grant counters and grant-protocol error flags.

module grant_cnt_lane #(
  parameter int CNT_W = 8
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end
endmodule

module grant_session_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic [3:0]         GRANT_IN,
  input  logic               ABORT,
  input  logic               CLR_ERR,
  output logic               BUSY,
  output logic [3:0]         USER_OH,
  output logic [1:0]         USER_ID,
  output logic [3:0]         RELEASE,
  output logic [4*CNT_W-1:0] GRANT_CNT,
  output logic               ERR_PULSE,
  output logic               ERR_STICKY
);
  localparam int NUM_USERS = 4;
  localparam int TW        = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, REL, WAIT_DROP} state_t;

  state_t                 st_q, st_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [NUM_USERS-1:0]   lat_q, lat_d, uoh_q, uoh_d, rel_q, rel_d;
  logic [1:0]             uid_q, uid_d, enc;
  logic                   busy_q, busy_d, err_q, err_d, sticky_q, sticky_d;
  logic                   one_hot, multi_hot, start;
  logic [NUM_USERS-1:0][CNT_W-1:0] cnt_q;

  assign one_hot   = (GRANT_IN != '0) && ((GRANT_IN & (GRANT_IN - 4'd1)) == '0);
  assign multi_hot = (GRANT_IN != '0) && !one_hot;
  assign start     = (st_q == IDLE) && one_hot;

  always_comb begin
    enc = '0;
    for (int i = 0; i < NUM_USERS; i++)
      if (GRANT_IN[i]) enc = 2'(i);
  end

  genvar g;
  generate
    for (g = 0; g < NUM_USERS; g++) begin : g_lane
      grant_cnt_lane #(.CNT_W(CNT_W)) u_cnt (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .inc     (start & GRANT_IN[g]),
        .cnt     (cnt_q[g])
      );
    end
  endgenerate

  always_comb begin
    st_d   = st_q;
    tmr_d  = tmr_q;
    lat_d  = lat_q;
    uid_d  = uid_q;
    uoh_d  = '0;
    rel_d  = '0;
    busy_d = 1'b0;
    err_d  = 1'b0;
    case (st_q)
      IDLE: begin
        if (one_hot) begin
          st_d   = ACTIVE;
          lat_d  = GRANT_IN;
          uid_d  = enc;
          tmr_d  = TW'(HOLD_CYCLES - 1);
          busy_d = 1'b1;
          uoh_d  = GRANT_IN;
        end else begin
          err_d  = multi_hot;
        end
      end
      ACTIVE: begin
        // A grant that disagrees with the owner is flagged but never disturbs the session.
        err_d = (GRANT_IN != '0) && (GRANT_IN != lat_q);
        if (ABORT || tmr_q == '0) begin
          st_d  = REL;
          rel_d = lat_q;
        end else begin
          tmr_d  = tmr_q - TW'(1);
          busy_d = 1'b1;
          uoh_d  = lat_q;
        end
      end
      REL: st_d = WAIT_DROP;
      WAIT_DROP: begin
        err_d = multi_hot;
        // Wait for the owner's grant to drop so a stale held grant cannot restart.
        if ((GRANT_IN & lat_q) == '0) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    sticky_d = err_d | (sticky_q & ~CLR_ERR);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      st_q     <= IDLE;
      tmr_q    <= '0;
      lat_q    <= '0;
      uid_q    <= '0;
      uoh_q    <= '0;
      rel_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      tmr_q    <= tmr_d;
      lat_q    <= lat_d;
      uid_q    <= uid_d;
      uoh_q    <= uoh_d;
      rel_q    <= rel_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign BUSY       = busy_q;
  assign USER_OH    = uoh_q;
  assign USER_ID    = uid_q;
  assign RELEASE    = rel_q;
  assign GRANT_CNT  = cnt_q;
  assign ERR_PULSE  = err_q;
  assign ERR_STICKY = sticky_q;
endmodule
